l2_cache_nway: RTL
==================

Name: l2_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 cache with tree pseudo-LRU replacement.
- Generalises the fixed 4-way / 8-set / 3-bit-LRU L2 to any power-of-two way and set count.
- Sits between the L1 arbiter, which issues line-granular requests, and physical memory.
- Contains its own tag, valid, dirty, LRU and data arrays, the control FSM, and hit/miss counters.

Parameters:
- WAYS, 4: associativity; power of two, >= 2.
- SETS, 8: number of sets; power of two, >= 2.
- ADDR_W, 16: byte address width.
- LINE_W, 128: line width in bits; offset bits OFS = log2(LINE_W/8); index bits IDX = log2(SETS); tag width = ADDR_W-IDX-OFS.
- CNT_W, 16: width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  upstream read request.
- mem_write  in  1  upstream write request (full line).
- mem_address  in  ADDR_W  upstream byte address; offset bits are ignored.
- mem_wdata  in  LINE_W  upstream write line.
- mem_rdata  out  LINE_W  read line.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  memory fill request.
- pmem_write  out  1  memory writeback request.
- pmem_address  out  ADDR_W  line-aligned memory address (offset bits 0).
- pmem_wdata  out  LINE_W  writeback line.
- pmem_rdata  in  LINE_W  fill line.
- pmem_resp  in  1  memory completion pulse.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (async, rst_n=0):
  - state = CHECK; all valid, dirty and LRU bits = 0; counters = 0.
  - mem_resp, pmem_read and pmem_write = 0.
  - The data and tag arrays are not reset.
  - Reset mid-WRITEBACK or mid-FILL abandons the transaction, drops pmem_* immediately, and leaves no line marked valid.
- Address split: tag = [ADDR_W-1:IDX+OFS], index = [IDX+OFS-1:OFS].
- Array reads are combinational from the current index.
- Upstream rules:
  - The request and its inputs are held stable until mem_resp.
  - If mem_read and mem_write are both 1, the request is treated as a write.
  - mem_resp is combinational in CHECK.
- State CHECK:
  - Idle when no request.
  - Request with a hit (valid & tag match in exactly one way):
    - mem_resp = 1 the same cycle.
    - Read: mem_rdata = way data.
    - Write: the data array is written with mem_wdata and dirty = 1 at the edge.
    - PLRU is updated; hit_count increments.
    - Hit latency is 1 cycle.
  - Request with a miss:
    - miss_count increments once (in this cycle only).
    - Victim = lowest-index invalid way, else the PLRU victim.
    - Victim valid & dirty -> WRITEBACK; else -> FILL.
    - The victim way is registered.
- State WRITEBACK:
  - pmem_write = 1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim data.
  - Outputs are held until pmem_resp, then -> FILL.
- State FILL:
  - pmem_read = 1; pmem_address = {request tag, index, 0}.
  - On pmem_resp: write pmem_rdata to the victim way, set tag, valid = 1, dirty = 0, then -> CHECK.
  - CHECK then hits (and counts a hit). Miss cost = WRITEBACK + FILL + 1 cycles.
- pmem_resp outside WRITEBACK or FILL is ignored.
- Tree PLRU (WAYS-1 bits per set, heap order, node 0 = root):
  - Node bit 0 means the victim lies in the lower-index half.
  - On each hit, every node on the path to the accessed way is set to point to the opposite half.
  - The victim is found by walking the bits from the root.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- pmem_read and pmem_write are never both 1.

Test Plan (WAYS=4, SETS=8, LINE_W=128, ADDR_W=16; set 0 addresses 0x0000, 0x0080, 0x0100, 0x0180, 0x0200):
- Cold read 0x0000: pmem_read=1 with pmem_address 0x0000, no pmem_write; return pattern A, then mem_resp with mem_rdata=A on the cycle after pmem_resp. Expect miss_count=1, hit_count=1.
- Read the same address again: mem_resp in the same cycle as the request, no pmem activity. Expect hit_count=2.
- Read 0x0000, 0x0080, 0x0100, 0x0180 (fills ways 0-3), then read 0x0200: victim way0 is clean, so no writeback and pmem_read addr=0x0200; a following read of 0x0000 misses.
- After reset, write B to 0x0000 (miss, fill, hit-write), then read 0x0080, 0x0100, 0x0180, then read 0x0200: pmem_write addr=0x0000 with data B, held until pmem_resp, then pmem_read addr=0x0200.
- Assert rst_n=0 with pmem_read high and no pmem_resp: pmem_read drops asynchronously and counters=0; a re-read of the same address misses.
- Preload hit_count to 0xFFFF via repeated hits: further hits keep it at 0xFFFF.

Source files
------------

// File: rtl/l2_cache_nway.sv
// rtl/l2_cache_nway.sv - N-way set-associative write-back L2 cache with tree PLRU
// Tag/valid/dirty/LRU/data arrays, CHECK/WRITEBACK/FILL control and saturating hit/miss counters.
module l2_cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int OFS    = $clog2(LINE_W / 8);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX - OFS;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [LINE_W-1:0] data_arr [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] valid_arr;
  logic [SETS-1:0][WAYS-1:0] dirty_arr;
  logic [SETS-1:0][WAYS-2:0] lru_arr;

  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   idx;
  logic             req;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] victim_q;
  logic             unused_ofs;

  assign req_tag    = mem_address[ADDR_W-1 -: TAG_W];
  assign idx        = mem_address[OFS +: IDX];
  assign req        = mem_read | mem_write;
  assign unused_ofs = ^mem_address[OFS-1:0];

  // Walk the tree from the root; each node bit picks the half holding the victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [NODE_W-1:0] node;
    logic [WAY_W-1:0]  w;
    node = '0;
    w    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      w    = WAY_W'({w, bits[node]});
      node = NODE_W'({node, 1'b1}) + NODE_W'(bits[node]);
    end
    return w;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]   r;
    logic [NODE_W-1:0] node;
    logic [WAY_W-1:0]  w;
    logic              b;
    r    = bits;
    node = '0;
    w    = way;
    for (int l = 0; l < WAY_W; l++) begin
      b       = w[WAY_W-1];
      r[node] = ~b;
      node    = NODE_W'({node, 1'b1}) + NODE_W'(b);
      w       = w << 1;
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[idx][w] && tag_arr[w][idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    victim = plru_victim(lru_arr[idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[idx][w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {req_tag, idx, OFS'(0)};
    pmem_wdata   = data_arr[victim_q][idx];
    mem_rdata    = data_arr[hit_way][idx];
    case (state)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
        end else if (req) begin
          state_next = (valid_arr[idx][victim] && dirty_arr[idx][victim]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_q][idx], idx, OFS'(0)};
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_next = CHECK;
      end
      default: state_next = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CHECK;
      victim_q   <= '0;
      valid_arr  <= '0;
      dirty_arr  <= '0;
      lru_arr    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (state == CHECK && req && hit) begin
        lru_arr[idx] <= plru_touch(lru_arr[idx], hit_way);
        if (mem_write) dirty_arr[idx][hit_way] <= 1'b1;
        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end else if (state == CHECK && req) begin
        victim_q <= victim;
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      if (state == FILL && pmem_resp) begin
        valid_arr[idx][victim_q] <= 1'b1;
        dirty_arr[idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CHECK && req && hit && mem_write) data_arr[hit_way][idx] <= mem_wdata;
    if (state == FILL && pmem_resp) begin
      data_arr[victim_q][idx] <= pmem_rdata;
      tag_arr[victim_q][idx]  <= req_tag;
    end
  end
endmodule
